audio_dac_out: RTL and testbench

AUDIO_DAC_OUT -- requirements
Module: audio_dac_out

---
 rtl/audio_dac_out.sv | 62 ++++++
 tb/tb_audio_dac_out.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_out.sv
// audio_dac_out: divided-rate sample capture driving a PWM or first-order sigma-delta 1-bit output
module audio_dac_out #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           WaveIn,
    input  logic                 Enable,
    input  logic                 Mode,
    input  logic [DIV_WIDTH-1:0] Divider,
    output logic                 AudioOut,
    output logic                 SampleTick,
    output logic [7:0]           Sample
);
    logic [DIV_WIDTH-1:0] cnt, period;
    logic [7:0] pwm, cmp;
    logic [8:0] acc;
    logic mode_q, match, mchg;
    always_comb begin
        match = cnt == period;
        mchg = Mode != mode_q;
    end
    always_ff @(posedge CLK) begin
        mode_q <= Mode;
        if (!RST) begin
            cnt <= '0;
            period <= Divider;
            pwm <= '0;
            cmp <= '0;
            acc <= '0;
            Sample <= '0;
            AudioOut <= 1'b0;
            SampleTick <= 1'b0;
        end else if (!Enable) begin
            cnt <= '0;
            period <= Divider;
            pwm <= '0;
            acc <= '0;
            AudioOut <= 1'b0;
            SampleTick <= 1'b0;
        end else begin
            cnt <= match ? '0 : cnt + DIV_WIDTH'(1);
            SampleTick <= match;
            if (match) begin
                period <= Divider;
                Sample <= WaveIn;
            end
            // a modulator switch restarts both modulators from a known silent state
            if (mchg) begin
                pwm <= '0;
                cmp <= '0;
                acc <= '0;
                AudioOut <= 1'b0;
            end else begin
                pwm <= pwm + 8'd1;
                if (pwm == 8'hff) cmp <= Sample;
                acc <= {1'b0, acc[7:0]} + {1'b0, Sample};
                AudioOut <= Mode ? acc[8] : pwm < cmp;
            end
        end
    end
endmodule

// File: tb/tb_audio_dac_out.sv
// tb_audio_dac_out: directed stimulus with a tick/sample scoreboard and direct output-stream checks
module tb_audio_dac_out;
    typedef struct {
        int         c;
        logic [7:0] s;
    } exp_t;

    logic clk, rst, enable, mode, audio_out, sample_tick;
    logic [7:0] wave_in, sample, divider;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t e;
    logic ao [768];
    logic [7:0] v3 [6] = '{8'd5, 8'd253, 8'd254, 8'd255, 8'd0, 8'd17};

    audio_dac_out dut (
        .CLK(clk), .RST(rst), .WaveIn(wave_in), .Enable(enable), .Mode(mode),
        .Divider(divider), .AudioOut(audio_out), .SampleTick(sample_tick), .Sample(sample)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_tick(input int c, input logic [7:0] s);
        exp_t x;
        x.c = c;
        x.s = s;
        exp_q.push_back(x);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sample_tick === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tick_unexpected: got tick with sample %0d at cycle %0d, expected none", sample, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (sample !== e.s || cyc != e.c) begin
                        errors++;
                        $display("FAIL tick_sample: got sample %0d at cycle %0d, expected %0d at cycle %0d", sample, cyc, e.s, e.c);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL tick_missing: got no tick at cycle %0d, expected sample %0d", cyc, e.s);
            end
        end
    end

    initial begin
        int c, ones, bad;
        rst = 0; enable = 1; mode = 0; divider = 8'd3; wave_in = 8'd99;
        repeat (3) @(negedge clk);
        check("rst_audio", audio_out, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_sample", sample, 0);

        // divider 3, WaveIn steps by 10 each clock
        c = cyc; rst = 1; wave_in = 8'd10;
        expect_tick(c + 4, 8'd40);
        expect_tick(c + 8, 8'd80);
        expect_tick(c + 12, 8'd120);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            wave_in = 8'(10 * (i + 1));
        end
        enable = 0; divider = 8'd0;
        repeat (2) @(negedge clk);
        check("dis_sample_hold", sample, 120);
        check("dis_audio", audio_out, 0);

        // divider 0: tick every cycle, 253..255 pass through
        c = cyc; enable = 1; wave_in = v3[0];
        for (int k = 0; k < 6; k++) expect_tick(c + 1 + k, v3[k]);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            wave_in = v3[k];
        end
        @(negedge clk);
        enable = 0; divider = 8'd7;
        repeat (2) @(negedge clk);

        // divider 7 -> 1 mid-period
        c = cyc; enable = 1;
        expect_tick(c + 8, 8'd107);
        expect_tick(c + 10, 8'd109);
        expect_tick(c + 12, 8'd111);
        expect_tick(c + 14, 8'd113);
        for (int j = 0; j < 15; j++) begin
            wave_in = 8'(100 + j);
            if (j == 3) divider = 8'd1;
            @(negedge clk);
        end
        enable = 0; divider = 8'd255; mode = 0; wave_in = 8'd64;
        repeat (2) @(negedge clk);

        // PWM, 256-clock sample period: capture and wrap coincide
        c = cyc; enable = 1;
        expect_tick(c + 256, 8'd64);
        expect_tick(c + 512, 8'd64);
        expect_tick(c + 768, 8'd64);
        for (int k = 0; k < 768; k++) begin
            @(negedge clk);
            ao[k] = audio_out;
        end
        enable = 0;
        for (int w = 0; w < 3; w++) begin
            ones = 0;
            for (int k = 0; k < 256; k++) ones += int'(ao[w * 256 + k]);
            check($sformatf("pwm_ones_w%0d", w), ones, w == 0 ? 0 : (w == 1 ? 113 : 64));
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (ao[512 + i] !== (i < 64)) bad++;
        check("pwm_contiguous", bad, 0);
        repeat (2) @(negedge clk);

        // Mode toggle mid-PWM period
        c = cyc; enable = 1;
        repeat (20) @(negedge clk);
        check("pwm_high_pre_toggle", audio_out, 1);
        mode = 1;
        @(negedge clk);
        check("toggle_audio_zero", audio_out, 0);
        check("toggle_sample_kept", sample, 64);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("sd_restart_%0d", i), audio_out, (i == 4 || i == 8) ? 1 : 0);
        end
        enable = 0; divider = 8'd0; wave_in = 8'd128;
        repeat (2) @(negedge clk);

        // sigma-delta 128 then 252
        c = cyc; enable = 1;
        for (int k = 0; k < 300; k++) expect_tick(c + 1 + k, k < 20 ? 8'd128 : 8'd252);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            ao[k] = audio_out;
            if (k == 19) wave_in = 8'd252;
        end
        enable = 0; mode = 0; divider = 8'd5; wave_in = 8'd200;
        for (int k = 10; k < 18; k++) check($sformatf("sd_alt_%0d", k), ao[k], k % 2);
        ones = 0;
        for (int k = 40; k < 296; k++) ones += int'(ao[k]);
        check("sd_252_ones", ones, 252);
        repeat (2) @(negedge clk);

        // reset mid-period
        c = cyc; enable = 1;
        expect_tick(c + 6, 8'd200);
        repeat (8) @(negedge clk);
        check("pre_rst_audio", audio_out, 1);
        rst = 0;
        @(negedge clk);
        check("midrst_audio", audio_out, 0);
        check("midrst_tick", sample_tick, 0);
        check("midrst_sample", sample, 0);
        rst = 1;
        expect_tick(c + 15, 8'd200);
        repeat (6) @(negedge clk);
        enable = 0;
        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
